// File: rtl/coin_pkg.sv
// Shared types and coin index constants for the change dispenser slice.
package coin_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        PULSE,
        GAP,
        DONE
    } state_t;

    localparam int unsigned COIN_Q = 2;
    localparam int unsigned COIN_D = 1;
    localparam int unsigned COIN_N = 0;

endpackage

// File: rtl/coin_select.sv
// Greedy coin picker: largest denomination that fits the remainder and is in stock.
module coin_select
    import coin_pkg::*;
#(
    parameter int unsigned MONEY_W = 8,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned DENOM_Q = 25,
    parameter int unsigned DENOM_D = 10,
    parameter int unsigned DENOM_N = 5
) (
    input  logic [MONEY_W-1:0] remaining,
    input  logic [CNT_W-1:0]   inv_q,
    input  logic [CNT_W-1:0]   inv_d,
    input  logic [CNT_W-1:0]   inv_n,
    output logic [2:0]         pick,
    output logic               none
);

    always_comb begin
        pick = '0;
        if (remaining >= MONEY_W'(DENOM_Q) && inv_q != '0) begin
            pick[COIN_Q] = 1'b1;
        end else if (remaining >= MONEY_W'(DENOM_D) && inv_d != '0) begin
            pick[COIN_D] = 1'b1;
        end else if (remaining >= MONEY_W'(DENOM_N) && inv_n != '0) begin
            pick[COIN_N] = 1'b1;
        end
        none = (pick == '0);
    end

endmodule

// File: rtl/coin_dispenser.sv
// Change dispenser: pays a requested amount one coin per pulse, largest first,
// with a cooldown after each pulse; reports coins paid and any shortfall.
module coin_dispenser
    import coin_pkg::*;
#(
    parameter int unsigned MONEY_W    = 8,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned DENOM_Q    = 25,
    parameter int unsigned DENOM_D    = 10,
    parameter int unsigned DENOM_N    = 5,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    input  logic [MONEY_W-1:0] req_amount,
    output logic               req_ready,
    input  logic               load_en,
    input  logic [CNT_W-1:0]   load_q,
    input  logic [CNT_W-1:0]   load_d,
    input  logic [CNT_W-1:0]   load_n,
    output logic [2:0]         coin_pulse,
    output logic               done,
    output logic [MONEY_W-1:0] short_amt,
    output logic [CNT_W-1:0]   Q,
    output logic [CNT_W-1:0]   D,
    output logic [CNT_W-1:0]   N,
    output logic [CNT_W-1:0]   inv_q,
    output logic [CNT_W-1:0]   inv_d,
    output logic [CNT_W-1:0]   inv_n
);

    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t             state_q, state_d;
    logic [MONEY_W-1:0] rem_q, rem_d;
    logic [MONEY_W-1:0] short_q, short_d;
    logic [2:0]         pick_q, pick_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [CNT_W-1:0]   paidq_q, paidq_d, paidd_q, paidd_d, paidn_q, paidn_d;
    logic [CNT_W-1:0]   invq_q, invq_d, invd_q, invd_d, invn_q, invn_d;

    logic [2:0] sel_pick;
    logic       sel_none;

    coin_select #(
        .MONEY_W (MONEY_W),
        .CNT_W   (CNT_W),
        .DENOM_Q (DENOM_Q),
        .DENOM_D (DENOM_D),
        .DENOM_N (DENOM_N)
    ) u_select (
        .remaining (rem_q),
        .inv_q     (invq_q),
        .inv_d     (invd_q),
        .inv_n     (invn_q),
        .pick      (sel_pick),
        .none      (sel_none)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            short_q <= '0;
            pick_q  <= '0;
            gap_q   <= '0;
            paidq_q <= '0;
            paidd_q <= '0;
            paidn_q <= '0;
            invq_q  <= '0;
            invd_q  <= '0;
            invn_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            short_q <= short_d;
            pick_q  <= pick_d;
            gap_q   <= gap_d;
            paidq_q <= paidq_d;
            paidd_q <= paidd_d;
            paidn_q <= paidn_d;
            invq_q  <= invq_d;
            invd_q  <= invd_d;
            invn_q  <= invn_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        short_d = short_q;
        pick_d  = pick_q;
        gap_d   = gap_q;
        paidq_d = paidq_q;
        paidd_d = paidd_q;
        paidn_d = paidn_q;
        invq_d  = invq_q;
        invd_d  = invd_q;
        invn_d  = invn_q;

        case (state_q)
            IDLE: begin
                if (load_en) begin
                    invq_d = load_q;
                    invd_d = load_d;
                    invn_d = load_n;
                end
                if (req_valid) begin
                    rem_d   = req_amount;
                    paidq_d = '0;
                    paidd_d = '0;
                    paidn_d = '0;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                // short_amt is captured here so it is already valid in the DONE cycle
                if (rem_q == '0 || sel_none) begin
                    short_d = rem_q;
                    state_d = DONE;
                end else begin
                    pick_d  = sel_pick;
                    state_d = PULSE;
                end
            end
            PULSE: begin
                if (pick_q[COIN_Q]) begin
                    invq_d  = invq_q - CNT_W'(1);
                    paidq_d = paidq_q + CNT_W'(1);
                    rem_d   = rem_q - MONEY_W'(DENOM_Q);
                end else if (pick_q[COIN_D]) begin
                    invd_d  = invd_q - CNT_W'(1);
                    paidd_d = paidd_q + CNT_W'(1);
                    rem_d   = rem_q - MONEY_W'(DENOM_D);
                end else begin
                    invn_d  = invn_q - CNT_W'(1);
                    paidn_d = paidn_q + CNT_W'(1);
                    rem_d   = rem_q - MONEY_W'(DENOM_N);
                end
                gap_d   = '0;
                state_d = (GAP_CYCLES == 0) ? SELECT : GAP;
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = SELECT;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready  = (state_q == IDLE);
    assign done       = (state_q == DONE);
    assign coin_pulse = (state_q == PULSE) ? pick_q : '0;
    assign short_amt  = short_q;
    assign Q          = paidq_q;
    assign D          = paidd_q;
    assign N          = paidn_q;
    assign inv_q      = invq_q;
    assign inv_d      = invd_q;
    assign inv_n      = invn_q;

endmodule

// File: tb/tb_coin_dispenser.sv
// Self-checking bench for coin_dispenser: cycle-schedule reference model,
// directed scenarios with literal expectations, then randomized requests.
module tb_coin_dispenser;

    localparam int MONEY_W = 8;
    localparam int CNT_W   = 4;
    localparam int DQ      = 25;
    localparam int DD      = 10;
    localparam int DN      = 5;
    localparam int GAPC    = 2;
    localparam int PER     = 2 + GAPC;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               req_valid = 1'b0;
    logic [MONEY_W-1:0] req_amount = '0;
    logic               req_ready;
    logic               load_en = 1'b0;
    logic [CNT_W-1:0]   load_q = '0, load_d = '0, load_n = '0;
    logic [2:0]         coin_pulse;
    logic               done;
    logic [MONEY_W-1:0] short_amt;
    logic [CNT_W-1:0]   pay_q, pay_d, pay_n;
    logic [CNT_W-1:0]   inv_q, inv_d, inv_n;

    always #5 clk = ~clk;

    coin_dispenser #(
        .MONEY_W    (MONEY_W),
        .CNT_W      (CNT_W),
        .DENOM_Q    (DQ),
        .DENOM_D    (DD),
        .DENOM_N    (DN),
        .GAP_CYCLES (GAPC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_amount (req_amount),
        .req_ready  (req_ready),
        .load_en    (load_en),
        .load_q     (load_q),
        .load_d     (load_d),
        .load_n     (load_n),
        .coin_pulse (coin_pulse),
        .done       (done),
        .short_amt  (short_amt),
        .Q          (pay_q),
        .D          (pay_d),
        .N          (pay_n),
        .inv_q      (inv_q),
        .inv_d      (inv_d),
        .inv_n      (inv_n)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: a request is a plan (how many of each coin) plus a
    // fixed cycle schedule; index 2 = Q, 1 = D, 0 = N.
    bit m_busy = 1'b0;
    int m_t = 0;
    int m_k = 0, m_nq = 0, m_nd = 0, m_nn = 0;
    int m_short = 0;
    int m_inv[3]  = '{0, 0, 0};
    int m_paid[3] = '{0, 0, 0};

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int coin_of(input int i);
        if (i < m_nq) return 2;
        if (i < m_nq + m_nd) return 1;
        return 0;
    endfunction

    function automatic int pulse_idx(input int t);
        if (t < 2 || ((t - 2) % PER) != 0) return -1;
        if ((t - 2) / PER >= m_k) return -1;
        return (t - 2) / PER;
    endfunction

    initial begin
        int rem, idx, c;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_busy = 1'b0;
                m_t = 0;
                m_short = 0;
                m_inv  = '{0, 0, 0};
                m_paid = '{0, 0, 0};
            end else if (m_busy) begin
                idx = pulse_idx(m_t);
                if (idx >= 0) begin
                    c = coin_of(idx);
                    m_inv[c]--;
                    m_paid[c]++;
                end
                if (m_t == 2 + m_k * PER) m_busy = 1'b0;
                m_t++;
            end else begin
                if (load_en) begin
                    m_inv[2] = int'(load_q);
                    m_inv[1] = int'(load_d);
                    m_inv[0] = int'(load_n);
                end
                if (req_valid) begin
                    rem  = int'(req_amount);
                    m_nq = min2(rem / DQ, m_inv[2]);
                    rem -= m_nq * DQ;
                    m_nd = min2(rem / DD, m_inv[1]);
                    rem -= m_nd * DD;
                    m_nn = min2(rem / DN, m_inv[0]);
                    rem -= m_nn * DN;
                    m_k = m_nq + m_nd + m_nn;
                    m_short = rem;
                    m_paid = '{0, 0, 0};
                    m_busy = 1'b1;
                    m_t = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [2:0] exp_pulse;
        bit         exp_done;
        int         i;
        if (chk_en) begin
            exp_pulse = '0;
            exp_done  = 1'b0;
            if (m_busy) begin
                i = pulse_idx(m_t);
                if (i >= 0) exp_pulse = 3'b001 << coin_of(i);
                exp_done = (m_t == 2 + m_k * PER);
            end
            check("coin_pulse", int'(coin_pulse), int'(exp_pulse));
            check("done", int'(done), int'(exp_done));
            check("req_ready", int'(req_ready), int'(!m_busy));
            check("inv_q", int'(inv_q), m_inv[2]);
            check("inv_d", int'(inv_d), m_inv[1]);
            check("inv_n", int'(inv_n), m_inv[0]);
            check("paid_Q", int'(pay_q), m_paid[2]);
            check("paid_D", int'(pay_d), m_paid[1]);
            check("paid_N", int'(pay_n), m_paid[0]);
            if (exp_done) check("short_amt", int'(short_amt), m_short);
        end
    end

    task automatic load_inv(input int q, input int d, input int n);
        @(negedge clk);
        load_en = 1'b1;
        load_q = CNT_W'(q);
        load_d = CNT_W'(d);
        load_n = CNT_W'(n);
        @(posedge clk);
        #1 load_en = 1'b0;
    endtask

    // Issues one request (optionally with a simultaneous load), optionally
    // pokes ignored strobes during cycle inj, and returns the done cycle.
    task automatic run_req(input int amt, input bit ld, input int q, input int d,
                           input int n, input int inj, output int done_cyc);
        @(negedge clk);
        req_valid  = 1'b1;
        req_amount = MONEY_W'(amt);
        load_en    = ld;
        load_q = CNT_W'(q);
        load_d = CNT_W'(d);
        load_n = CNT_W'(n);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        load_en   = 1'b0;
        done_cyc  = -1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (c == inj) begin
                req_valid  = 1'b1;
                req_amount = MONEY_W'($urandom_range(0, 255));
                load_en    = 1'b1;
                load_q = 4'd0;
                load_d = 4'd2;
                load_n = 4'd0;
            end
            if (c == inj + 1) begin
                req_valid = 1'b0;
                load_en   = 1'b0;
            end
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        req_valid = 1'b0;
        load_en   = 1'b0;
        check("done_seen", int'(done_cyc >= 0), 1);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dc;
        bit seen;
        repeat (3) @(negedge clk);
        check("rst_ready", int'(req_ready), 1);
        check("rst_pulse", int'(coin_pulse), 0);
        check("rst_done", int'(done), 0);
        check("rst_inv_q", int'(inv_q), 0);
        check("rst_short", int'(short_amt), 0);
        chk_en = 1'b1;
        reset = 1'b1;

        // 40c from 5/5/5: Q, D, N then done at cycle 14
        load_inv(5, 5, 5);
        run_req(40, 1'b0, 0, 0, 0, -1, dc);
        check("t1_done_cycle", dc, 14);
        check("t1_Q", int'(pay_q), 1);
        check("t1_D", int'(pay_d), 1);
        check("t1_N", int'(pay_n), 1);
        check("t1_short", int'(short_amt), 0);
        check("t1_inv_d", int'(inv_d), 4);

        // greedy shortfall: 30c with Q=1, D=3, N=0
        load_inv(1, 3, 0);
        run_req(30, 1'b0, 0, 0, 0, -1, dc);
        check("t2_done_cycle", dc, 6);
        check("t2_short", int'(short_amt), 5);
        check("t2_Q", int'(pay_q), 1);
        check("t2_inv_q", int'(inv_q), 0);

        run_req(0, 1'b0, 0, 0, 0, -1, dc);
        check("t3_done_cycle", dc, 2);
        check("t3_short", int'(short_amt), 0);

        load_inv(15, 15, 15);
        run_req(7, 1'b0, 0, 0, 0, -1, dc);
        check("t4_short", int'(short_amt), 2);
        check("t4_N", int'(pay_n), 1);

        // strobes during GAP are ignored, then load+request in the same IDLE cycle
        run_req(40, 1'b0, 0, 0, 0, 3, dc);
        check("t5_inv_q", int'(inv_q), 14);
        check("t5_inv_n", int'(inv_n), 13);
        run_req(20, 1'b1, 0, 2, 0, -1, dc);
        check("t5_D", int'(pay_d), 2);
        check("t5_short", int'(short_amt), 0);
        check("t5_done_cycle", dc, 10);

        // reset after the first Q pulse of a 75c request
        load_inv(3, 0, 0);
        @(negedge clk);
        req_valid  = 1'b1;
        req_amount = 8'd75;
        @(posedge clk);
        #1 req_valid = 1'b0;
        seen = 1'b0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            seen = (coin_pulse != '0);
        end
        check("t6_pulse_seen", int'(seen), 1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("t6_pulse", int'(coin_pulse), 0);
        check("t6_done", int'(done), 0);
        check("t6_ready", int'(req_ready), 1);
        check("t6_Q", int'(pay_q), 0);
        check("t6_inv_q", int'(inv_q), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        for (int it = 0; it < 60; it++) begin
            bit ld;
            int inj;
            if ($urandom_range(0, 1) == 1)
                load_inv($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
            ld  = ($urandom_range(0, 3) == 0);
            inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : -1;
            run_req($urandom_range(0, 130), ld, $urandom_range(0, 15),
                    $urandom_range(0, 15), $urandom_range(0, 15), inj, dc);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
